// File: rtl/hs_gl_pkg.sv
// Shared constants and reference model for the hs_gl half-subtractor array.
package hs_gl_pkg;

  localparam int unsigned HS_WIDTH = 1;

  // Reference half subtractor: returns {borrow, difference} for one lane.
  function automatic logic [1:0] hs_ref(input logic a, input logic b);
    logic bo;
    logic di;
    bo = ~a & b;
    di = a ^ b;
    return {bo, di};
  endfunction

endpackage

// File: rtl/hs_bit.sv
// One combinational gate-level half-subtractor lane.
module hs_bit (
  input  logic a,
  input  logic b,
  output logic borrow,
  output logic difference
);

  logic a_n;

  // Difference is the XOR of the operands.
  xor g_diff (difference, a, b);

  // A borrow is needed only when subtracting 1 from 0.
  not g_inv (a_n, a);
  and g_borrow (borrow, a_n, b);

endmodule

// File: rtl/hs_gl.sv
// Registered array of independent half-subtractor lanes, one-cycle latency.
module hs_gl
  import hs_gl_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  output logic [WIDTH-1:0] borrow,
  output logic [WIDTH-1:0] difference,
  output logic             out_valid
);

  logic [WIDTH-1:0] borrow_c;
  logic [WIDTH-1:0] difference_c;

  // Independent lanes: no borrow chaining between them.
  generate
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
      hs_bit u_bit (
        .a          (ip1[i]),
        .b          (ip2[i]),
        .borrow     (borrow_c[i]),
        .difference (difference_c[i])
      );
    end
  endgenerate

  // Output stage: capture on valid, hold otherwise; valid is a one-cycle pulse per input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow     <= '0;
      difference <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        borrow     <= borrow_c;
        difference <= difference_c;
      end
    end
  end

endmodule

// File: tb/tb_hs_gl.sv
// Scoreboard bench for hs_gl at WIDTH=1 and WIDTH=4.
module tb_hs_gl;
  import hs_gl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       v1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       bo1;
  logic       di1;
  logic       ov1;

  logic       v4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [3:0] bo4;
  logic [3:0] di4;
  logic       ov4;

  logic [1:0] q1[$];
  logic [7:0] q4[$];
  logic [1:0] hold1 = '0;
  logic [7:0] hold4 = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hs_gl #(.WIDTH(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v1),
    .ip1        (a1),
    .ip2        (b1),
    .borrow     (bo1),
    .difference (di1),
    .out_valid  (ov1)
  );

  hs_gl #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v4),
    .ip1        (a4),
    .ip2        (b4),
    .borrow     (bo4),
    .difference (di4),
    .out_valid  (ov4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Lane-wise reference packed as {borrow[3:0], difference[3:0]}.
  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] r;
    logic [1:0] l;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      l = hs_ref(a[i], b[i]);
      r[4+i] = l[1];
      r[i]   = l[0];
    end
    return r;
  endfunction

  // Push expectations for current inputs, advance one edge, then score both DUTs.
  task automatic cycle(input string tag);
    logic ev1;
    logic ev4;
    if (v1) q1.push_back(hs_ref(a1, b1));
    if (v4) q4.push_back(ref4(a4, b4));
    ev1 = v1;
    ev4 = v4;
    @(posedge clk);
    #1;
    check({tag, "_ov1"}, 32'(ov1), 32'(ev1));
    if (ov1) begin
      if (q1.size() == 0) check({tag, "_q1_empty"}, 32'(1), 32'(0));
      else hold1 = q1.pop_front();
    end
    check({tag, "_res1"}, 32'({bo1, di1}), 32'(hold1));
    check({tag, "_ov4"}, 32'(ov4), 32'(ev4));
    if (ov4) begin
      if (q4.size() == 0) check({tag, "_q4_empty"}, 32'(1), 32'(0));
      else hold4 = q4.pop_front();
    end
    check({tag, "_res4"}, 32'({bo4, di4}), 32'(hold4));
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic reset_mid(input string tag);
    #2;
    rst_n = 1'b0;
    q1.delete();
    q4.delete();
    hold1 = '0;
    hold4 = '0;
    #1;
    check({tag, "_rst1"}, 32'({ov1, bo1, di1}), 32'(0));
    check({tag, "_rst4"}, 32'({ov4, bo4, di4}), 32'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    check("por1", 32'({ov1, bo1, di1}), 32'(0));
    check("por4", 32'({ov4, bo4, di4}), 32'(0));
    release_reset();

    // WIDTH=1 truth table, back-to-back.
    v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      cycle("tt");
    end
    v1 = 1'b0;
    cycle("tt_idle");

    // Load (0,1) -> (1,1), then reset asynchronously while it is held.
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    v4 = 1'b1; a4 = 4'b0000; b4 = 4'b1111;
    cycle("pre_rst");
    v1 = 1'b0; v4 = 1'b0;
    reset_mid("rst_hold");
    @(posedge clk);
    release_reset();
    cycle("post_rst");
    cycle("post_rst2");

    // Hold: load (0,1), then idle with changed inputs.
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    cycle("hold_load");
    v1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
    for (int i = 0; i < 3; i++) cycle("hold");
    check("hold_val", 32'({bo1, di1}), 32'(2'b11));

    // WIDTH=4 directed vector; lanes must not interact.
    v4 = 1'b1; a4 = 4'b1010; b4 = 4'b0110;
    cycle("w4_dir");
    check("w4_dir_abs", 32'({bo4, di4}), 32'({4'b0100, 4'b1100}));

    // Exhaustive 256 pairs back-to-back on WIDTH=4, random traffic on WIDTH=1.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] p;
      p = 8'(i);
      a4 = p[7:4];
      b4 = p[3:0];
      v1 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      cycle("exh");
    end

    // Reset mid-stream: a valid input pending at reset assertion must never surface.
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    a4 = 4'b0011; b4 = 4'b1100;
    cycle("burst");
    a1 = 1'b1; b1 = 1'b0;
    a4 = 4'b0101; b4 = 4'b1010;
    reset_mid("abort");
    @(posedge clk);
    #1;
    check("abort_in_rst", 32'({ov4, bo4, di4}), 32'(0));
    v1 = 1'b0; v4 = 1'b0;
    release_reset();
    cycle("abort_rel");
    cycle("abort_rel2");

    // Resume after abort to confirm normal operation.
    v4 = 1'b1; a4 = 4'b1111; b4 = 4'b0001;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    cycle("resume");
    v1 = 1'b0; v4 = 1'b0;
    cycle("resume_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
